// File: rtl/sao_stat_sched.sv
// SAO statistics scheduler: for each accepted CTU it sequences the luma and
// the chroma components through a WAIT phase and then a raster SCAN over the
// component's 2x2 blocks. It also produces the per-component phase strobes
// (band-offset window, refresh pulse, component and CTU completion).
module sao_stat_sched #(
    parameter int WAIT_LUMA     = 35,
    parameter int WAIT_CHROMA   = 30,
    parameter int BO_LUMA       = 32,
    parameter int BO_CHROMA     = 16,
    parameter int REFRESH_CYCLE = 22,
    parameter int XW            = 6,
    parameter int YW            = 6,
    parameter int CNTW          = 11
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          rst_n,
    input  logic          start,
    output logic          start_rdy,
    input  logic [1:0]    chroma_fmt,
    input  logic [XW-1:0] x_len,
    input  logic [YW-1:0] y_len,
    input  logic          stall,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [1:0]    cidx,
    output logic          busy,
    output logic          wait_pre,
    output logic          bo_phase,
    output logic          refresh,
    output logic          comp_done,
    output logic          ctu_done
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN} state_t;

    localparam logic [CNTW-1:0] WAIT_L_END = CNTW'(WAIT_LUMA - 1);
    localparam logic [CNTW-1:0] WAIT_C_END = CNTW'(WAIT_CHROMA - 1);
    localparam logic [CNTW-1:0] BO_L       = CNTW'(BO_LUMA);
    localparam logic [CNTW-1:0] BO_C       = CNTW'(BO_CHROMA);
    localparam logic [CNTW-1:0] REF_CNT    = CNTW'(REFRESH_CYCLE);
    localparam logic [CNTW-1:0] CNT_MAX    = '1;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [1:0]    cidx_q, cidx_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [1:0]    fmt_q, fmt_d;
    logic [XW-1:0] xlen_q, xlen_d;
    logic [YW-1:0] ylen_q, ylen_d;

    logic [XW-1:0]   xl;
    logic [YW-1:0]   yl;
    logic            last_blk;
    logic            last_comp;
    logic [CNTW-1:0] cnt_inc;

    // Per-component scan limits; chroma limits shrink by a logical shift so
    // a zero length stays zero.
    always_comb begin
        xl = xlen_q;
        yl = ylen_q;
        if (cidx_q != 2'd0) begin
            case (fmt_q)
                2'd1: begin
                    xl = xlen_q >> 1;
                    yl = ylen_q >> 1;
                end
                2'd2: xl = xlen_q >> 1;
                default: ;
            endcase
        end
    end

    assign last_blk  = (x_q == xl) && (y_q == yl);
    assign last_comp = (cidx_q == 2'd2) || (fmt_q == 2'd0);
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Next-state logic; a stall leaves every register unchanged.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cidx_d  = cidx_q;
        cnt_d   = cnt_q;
        fmt_d   = fmt_q;
        xlen_d  = xlen_q;
        ylen_d  = ylen_q;
        if (!stall) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        fmt_d   = chroma_fmt;
                        xlen_d  = x_len;
                        ylen_d  = y_len;
                        cidx_d  = 2'd0;
                        cnt_d   = '0;
                        x_d     = '0;
                        y_d     = '0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == ((cidx_q == 2'd0) ? WAIT_L_END : WAIT_C_END)) begin
                        state_d = S_SCAN;
                    end
                end
                S_SCAN: begin
                    cnt_d = cnt_inc;
                    if (last_blk) begin
                        x_d   = '0;
                        y_d   = '0;
                        cnt_d = '0;
                        if (last_comp) begin
                            cidx_d  = 2'd0;
                            state_d = S_IDLE;
                        end else begin
                            cidx_d  = cidx_q + 2'd1;
                            state_d = S_WAIT;
                        end
                    end else if (x_q == xl) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control registers: async power-on reset plus synchronous clear.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cidx_q  <= 2'd0;
            cnt_q   <= '0;
        end else if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cidx_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cidx_q  <= cidx_d;
            cnt_q   <= cnt_d;
        end
    end

    // CTU configuration captured on accept; only meaningful while busy.
    always_ff @(posedge clk) begin
        fmt_q  <= fmt_d;
        xlen_q <= xlen_d;
        ylen_q <= ylen_d;
    end

    assign busy      = (state_q != S_IDLE);
    assign start_rdy = (state_q == S_IDLE);
    assign wait_pre  = (state_q == S_WAIT);
    assign bo_phase  = busy && (cnt_q < ((cidx_q == 2'd0) ? BO_L : BO_C));
    assign refresh   = busy && (cnt_q == REF_CNT) && !stall;
    assign comp_done = (state_q == S_SCAN) && last_blk && !stall;
    assign ctu_done  = comp_done && last_comp;
    assign x         = x_q;
    assign y         = y_q;
    assign cidx      = cidx_q;

endmodule

// File: tb/tb_sao_stat_sched.sv
// Directed bench for sao_stat_sched: runs whole CTUs in several formats and
// checks event cycles (counted from the accept edge), scan ranges, stall and
// reset behaviour against hand-computed values.
module tb_sao_stat_sched;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       start_rdy;
    logic [1:0] chroma_fmt = 2'd0;
    logic [5:0] x_len = '0;
    logic [5:0] y_len = '0;
    logic       stall = 1'b0;
    logic [5:0] x;
    logic [5:0] y;
    logic [1:0] cidx;
    logic       busy, wait_pre, bo_phase, refresh, comp_done, ctu_done;

    int n_chk = 0;
    int n_fail = 0;

    int cd_cyc [4];
    int n_cd, ctu_cyc, n_ctu, ref_first, n_ref, n_wait_l, n_bo_l;
    int bad, cidx_max, cxmax, cymax;
    bit done;

    sao_stat_sched dut (
        .clk(clk), .arst_n(arst_n), .rst_n(rst_n),
        .start(start), .start_rdy(start_rdy),
        .chroma_fmt(chroma_fmt), .x_len(x_len), .y_len(y_len),
        .stall(stall), .x(x), .y(y), .cidx(cidx),
        .busy(busy), .wait_pre(wait_pre), .bo_phase(bo_phase),
        .refresh(refresh), .comp_done(comp_done), .ctu_done(ctu_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept one CTU, then sample cycle k (k=1.. after the accept edge) at the
    // falling edge; ends on ctu_done, or one cycle after a synchronous clear.
    task automatic run(input int budget, input int st_at, input int st_len,
                       input bit hold, input int rst_at);
        int px, py;
        px = 0; py = 0;
        n_cd = 0; ctu_cyc = -1; n_ctu = 0; ref_first = -1; n_ref = 0;
        n_wait_l = 0; n_bo_l = 0; bad = 0; cidx_max = 0; cxmax = 0; cymax = 0;
        done = 1'b0;
        for (int i = 0; i < 4; i++) cd_cyc[i] = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = hold;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            stall = (k >= st_at) && (k < st_at + st_len);
            rst_n = (k != rst_at);
            #1;
            if (comp_done) begin
                if (n_cd < 4) cd_cyc[n_cd] = k;
                n_cd++;
            end
            if (ctu_done) begin ctu_cyc = k; n_ctu++; end
            if (refresh) begin
                if (n_ref == 0) ref_first = k;
                n_ref++;
            end
            if (wait_pre && cidx == 2'd0) n_wait_l++;
            if (bo_phase && cidx == 2'd0) n_bo_l++;
            if (wait_pre && (x != 0 || y != 0)) bad++;
            if (int'(cidx) > cidx_max) cidx_max = int'(cidx);
            if (busy && cidx != 2'd0) begin
                if (int'(x) > cxmax) cxmax = int'(x);
                if (int'(y) > cymax) cymax = int'(y);
            end
            if (k > st_at && k <= st_at + st_len && (int'(x) != px || int'(y) != py)) bad++;
            if (stall && (refresh || comp_done || ctu_done)) bad++;
            px = int'(x); py = int'(y);
            if (ctu_done || k == rst_at + 1) begin
                done = 1'b1;
                break;
            end
        end
        stall = 1'b0;
        start = 1'b0;
        rst_n = 1'b1;
        chk("run_terminated", int'(done), 1);
    endtask

    task automatic idle_after;
        @(negedge clk);
        #1;
        chk("start_rdy_after", int'(start_rdy), 1);
        chk("busy_after", int'(busy), 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_start_rdy", int'(start_rdy), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulses", int'({refresh, comp_done, ctu_done, wait_pre, bo_phase}), 0);
        chk("rst_xyc", int'({x, y, cidx}), 0);
        arst_n = 1'b1;
        @(negedge clk);

        // 4:2:0, 30x30 luma blocks
        chroma_fmt = 2'd1; x_len = 6'd29; y_len = 6'd29;
        run(3000, 0, 0, 1'b0, -10);
        chk("f1_ncd", n_cd, 3);
        chk("f1_cd0", cd_cyc[0], 935);
        chk("f1_cd1", cd_cyc[1], 1190);
        chk("f1_cd2", cd_cyc[2], 1445);
        chk("f1_ctu", ctu_cyc, 1445);
        chk("f1_nref", n_ref, 3);
        chk("f1_ref_first", ref_first, 23);
        chk("f1_wait_luma", n_wait_l, 35);
        chk("f1_bo_luma", n_bo_l, 32);
        chk("f1_chroma_xmax", cxmax, 14);
        chk("f1_chroma_ymax", cymax, 14);
        chk("f1_bad", bad, 0);
        idle_after();

        // 4:0:0: luma only
        chroma_fmt = 2'd0;
        run(2000, 0, 0, 1'b0, -10);
        chk("f0_ncd", n_cd, 1);
        chk("f0_cd0", cd_cyc[0], 935);
        chk("f0_ctu", ctu_cyc, 935);
        chk("f0_cidx_max", cidx_max, 0);
        idle_after();

        // 4:2:2
        chroma_fmt = 2'd2;
        run(3000, 0, 0, 1'b0, -10);
        chk("f2_cd0", cd_cyc[0], 935);
        chk("f2_cd1", cd_cyc[1], 1415);
        chk("f2_cd2", cd_cyc[2], 1895);
        chk("f2_ctu", ctu_cyc, 1895);
        chk("f2_chroma_xmax", cxmax, 14);
        chk("f2_chroma_ymax", cymax, 29);
        chk("f2_bad", bad, 0);
        idle_after();

        // 10-cycle stall inside luma SCAN
        chroma_fmt = 2'd1;
        run(3000, 100, 10, 1'b0, -10);
        chk("st_cd0", cd_cyc[0], 945);
        chk("st_ctu", ctu_cyc, 1455);
        chk("st_nref", n_ref, 3);
        chk("st_ref_first", ref_first, 23);
        chk("st_frozen", bad, 0);
        idle_after();

        // Stall rising during the completion cycle defers the pulses
        chroma_fmt = 2'd0;
        run(2000, 935, 3, 1'b0, -10);
        chk("stcd_ncd", n_cd, 1);
        chk("stcd_ctu", ctu_cyc, 938);
        chk("stcd_bad", bad, 0);
        idle_after();

        // Single block per component, 4:4:4, start held high throughout
        chroma_fmt = 2'd3; x_len = 6'd0; y_len = 6'd0;
        run(500, 0, 0, 1'b1, -10);
        chk("one_cd0", cd_cyc[0], 36);
        chk("one_cd1", cd_cyc[1], 67);
        chk("one_cd2", cd_cyc[2], 98);
        chk("one_ctu", ctu_cyc, 98);
        chk("one_nctu", n_ctu, 1);
        idle_after();

        // Single block, 4:2:0: chroma limits clamp to 0
        chroma_fmt = 2'd1;
        run(500, 0, 0, 1'b0, -10);
        chk("z420_ctu", ctu_cyc, 98);
        chk("z420_cxmax", cxmax, 0);
        idle_after();

        // Synchronous clear in the middle of the first chroma scan
        chroma_fmt = 2'd1; x_len = 6'd29; y_len = 6'd29;
        run(3000, 0, 0, 1'b0, 1000);
        chk("srst_ncd", n_cd, 1);
        chk("srst_nctu", n_ctu, 0);
        chk("srst_busy", int'(busy), 0);
        chk("srst_rdy", int'(start_rdy), 1);
        chk("srst_cidx", int'(cidx), 0);

        // Asynchronous reset while waiting
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("arst_pre_busy", int'(busy), 1);
        arst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_rdy", int'(start_rdy), 1);
        chk("arst_wait_pre", int'(wait_pre), 0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("arst_stays_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sao_stat_sched.md
SAO_STAT_SCHED -- requirements
Module: sao_stat_sched

Interface
REQ-001 SHALL have parameter WAIT_LUMA, default 35: idle cycles before a luma scan.
REQ-002 SHALL have parameter WAIT_CHROMA, default 30: idle cycles before each chroma scan.
REQ-003 SHALL have parameter BO_LUMA, default 32, and BO_CHROMA, default 16: band-offset collect window length per component.
REQ-004 SHALL have parameter REFRESH_CYCLE, default 22: component-relative cycle that pulses refresh.
REQ-005 SHALL have parameters XW, default 6, YW, default 6, and CNTW, default 11: coordinate and counter widths.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port arst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port rst_n, input, 1: synchronous clear, active-low.
REQ-009 SHALL have ports start input 1 and start_rdy output 1: CTU request/accept handshake.
REQ-010 SHALL have port chroma_fmt, input, 2: 0=4:0:0, 1=4:2:0, 2=4:2:2, 3=4:4:4; latched on accept.
REQ-011 SHALL have ports x_len input XW and y_len input YW: last luma 2x2-block index; latched on accept.
REQ-012 SHALL have port stall, input, 1: freeze all state.
REQ-013 SHALL have ports x output XW, y output YW, cidx output 2: current block and component.
REQ-014 SHALL have outputs busy, wait_pre, bo_phase, refresh, comp_done and ctu_done, each 1 bit.

Function
REQ-015 SHALL implement the states IDLE, WAIT, SCAN; busy=(state!=IDLE); start_rdy=(state==IDLE).
REQ-016 SHALL accept a CTU when start&&start_rdy&&!stall: latch config, cidx=0, cnt=0, x=y=0, next state WAIT; start is ignored in any other case.
REQ-017 SHALL keep x=y=0 in WAIT; WAIT lasts WAIT_LUMA cycles when cidx==0, else WAIT_CHROMA cycles; then SCAN.
REQ-018 SHALL use component limits xl/yl: luma xl=x_len, yl=y_len; fmt1 xl=x_len>>1, yl=y_len>>1; fmt2 xl=x_len>>1, yl=y_len; fmt3 xl=x_len, yl=y_len.
REQ-019 SHALL in SCAN step x by 1 per cycle; at x==xl set x=0 and y+=1; SCAN lasts (xl+1)*(yl+1) cycles.
REQ-020 SHALL assert comp_done for one cycle in the SCAN cycle where x==xl && y==yl.
REQ-021 SHALL after that cycle go to WAIT with cidx+1 when cidx<2 and fmt!=0; otherwise assert ctu_done in the same cycle and go to IDLE.
REQ-022 SHALL run cnt from 0 on the first WAIT cycle of each component, incrementing every non-stalled cycle; cnt saturates at all-ones.
REQ-023 SHALL drive wait_pre=(state==WAIT).
REQ-024 SHALL drive bo_phase=busy && cnt<(cidx==0 ? BO_LUMA : BO_CHROMA).
REQ-025 SHALL drive refresh=busy && cnt==REFRESH_CYCLE && !stall.
REQ-026 SHALL while stall=1 hold state, cnt, x, y, cidx, and force refresh, comp_done and ctu_done to 0.
REQ-027 SHALL pulse comp_done and ctu_done in the first unstalled cycle if stall rises during their cycle.
REQ-028 SHALL with x_len=y_len=0 scan exactly one block per component.
REQ-029 SHALL in 4:2:0/4:2:2 with x_len=0 or y_len=0 give the chroma limits value 0 via the shift, never negative.

Reset
REQ-030 SHALL on arst_n low (async) or rst_n low at a clk edge enter IDLE with x=y=0, cidx=0, cnt=0 and all pulse outputs 0, start_rdy=1, busy=0.
REQ-031 SHALL abort a CTU in progress on reset without emitting comp_done or ctu_done.

Verification
REQ-032 SHALL check fmt=1, x_len=y_len=29 -> luma comp_done 935 cycles after accept, chroma comp_done at 1190 and 1445, ctu_done at 1445, then start_rdy=1.
REQ-033 SHALL check fmt=0, x_len=y_len=29 -> single comp_done coinciding with ctu_done at cycle 935; cidx stays 0.
REQ-034 SHALL check fmt=2, x_len=y_len=29 -> each chroma scan has x 0..14, y 0..29; comp_done at 935, 1415 and 1895.
REQ-035 SHALL check stall held 10 cycles inside luma SCAN -> x/y frozen, ctu_done delayed exactly 10 cycles, refresh single-pulse per component at cnt 22.
REQ-036 SHALL check start held high while busy -> ignored; rst_n low mid-chroma -> IDLE next cycle with no ctu_done.
REQ-037 SHALL check x_len=y_len=0, fmt=3 -> three components of 36, 31, 31 cycles; ctu_done at cycle 98.
